// File: rtl/drbg_video_pkg.sv
// Shared defaults and helpers for the DRBG-to-video cut-position path.
// Holds the word/chunk widths and the request FSM encoding.
package drbg_video_pkg;

  localparam int unsigned DRBG_WORD_W = 256;
  localparam int unsigned CUT_POS_W   = 8;

  typedef enum logic {
    REQ_IDLE,
    REQ_WAIT_DATA
  } req_state_e;

  function automatic int unsigned chunk_count(input int unsigned word_w,
                                              input int unsigned chunk_w);
    return word_w / chunk_w;
  endfunction

endpackage

// File: rtl/drbg_line_key_serializer_rise_detect.sv
// Registered rising-edge detector: flags the first cycle a level is sampled high.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/drbg_line_key_serializer.sv
// Slices generator words into per-line cut positions, double-buffering one word
// ahead and discarding all buffered randomness at each vertical-sync rise.
module drbg_line_key_serializer
  import drbg_video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN  = DRBG_WORD_W,
  parameter int unsigned DATA_WIDTH_OUT = CUT_POS_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      H,
  input  logic                      V,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      data_in_valid,
  input  logic                      generator_busy,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      data_out_valid,
  output logic                      need_next
);

  localparam int unsigned N     = chunk_count(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((DATA_WIDTH_IN % DATA_WIDTH_OUT) != 0) begin : g_width_check
      $error("DATA_WIDTH_IN must be a multiple of DATA_WIDTH_OUT");
    end
  endgenerate

  logic h_rise, v_rise;

  rise_detect u_h_rise (.clk(clk), .reset_n(reset_n), .sig_i(H), .rise_o(h_rise));
  rise_detect u_v_rise (.clk(clk), .reset_n(reset_n), .sig_i(V), .rise_o(v_rise));

  req_state_e               state_q, state_d;
  logic                     need_next_q, need_next_d;
  logic [DATA_WIDTH_IN-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic                     cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  logic pending, accept, advance, req_ok;

  assign pending = (state_q == REQ_WAIT_DATA);
  assign accept  = pending && data_in_valid && !v_rise;
  assign advance = h_rise && !V && cur_vld_q;
  assign req_ok  = !V && !generator_busy && (!cur_vld_q || !nxt_vld_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= REQ_IDLE;
      need_next_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      need_next_q <= need_next_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ_IDLE:      if (req_ok) state_d = REQ_WAIT_DATA;
      REQ_WAIT_DATA: if (accept) state_d = REQ_IDLE;
      default:       state_d = REQ_IDLE;
    endcase
    if (v_rise) state_d = REQ_IDLE;
  end

  always_comb begin
    need_next_d = (state_q == REQ_IDLE) && req_ok;
  end

  // Advance is resolved before accept so a word arriving as the last chunk
  // retires lands straight in cur without a gap in data_out_valid.
  always_comb begin
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    cur_vld_d = cur_vld_q;
    nxt_vld_d = nxt_vld_q;
    idx_d     = idx_q;
    if (v_rise) begin
      cur_vld_d = 1'b0;
      nxt_vld_d = 1'b0;
      idx_d     = '0;
    end else begin
      if (advance) begin
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + 1'b1;
        end else if (nxt_vld_q) begin
          cur_d     = nxt_q;
          idx_d     = '0;
          nxt_vld_d = 1'b0;
        end else begin
          cur_vld_d = 1'b0;
        end
      end
      if (accept) begin
        if (!cur_vld_d) begin
          cur_d     = data_in;
          cur_vld_d = 1'b1;
          idx_d     = '0;
        end else begin
          nxt_d     = data_in;
          nxt_vld_d = 1'b1;
        end
      end
    end
  end

  // NOTE: the word slots are plain registers and are reset so data_out reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q     <= '0;
      nxt_q     <= '0;
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    data_out = cur_q[int'(idx_q) * DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
  end

  assign data_out_valid = cur_vld_q;
  assign need_next      = need_next_q;

endmodule

// File: tb/tb_drbg_line_key_serializer.sv
// Directed bench for drbg_line_key_serializer: load, stepping, starvation,
// flush, same-cycle accept/advance and mid-stream reset.
module tb_drbg_line_key_serializer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         H, V;
  logic [255:0] data_in;
  logic         data_in_valid;
  logic         generator_busy;
  logic [7:0]   data_out;
  logic         data_out_valid;
  logic         need_next;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  drbg_line_key_serializer dut (
    .clk(clk), .reset_n(reset_n), .H(H), .V(V),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .generator_busy(generator_busy),
    .data_out(data_out), .data_out_valid(data_out_valid), .need_next(need_next)
  );

  function automatic logic [255:0] mk_word(input logic [7:0] base);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 32; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_need(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (need_next) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic reply(input logic [255:0] w, input logic busy_after);
    data_in        = w;
    data_in_valid  = 1'b1;
    generator_busy = busy_after;
    tick();
    data_in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; H = 1'b0; V = 1'b0;
    data_in = '0; data_in_valid = 1'b0; generator_busy = 1'b0;
    #3;
    total++;
    if ({data_out, data_out_valid, need_next} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%b/%b want 00/0/0", data_out, data_out_valid, need_next);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (need_next !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_req: need_next=%b want 1", need_next);
    end
    tick();
    total++;
    if (need_next !== 1'b0) begin
      bad++;
      $display("FAIL reset_req_single: need_next=%b want 0", need_next);
    end
  endtask

  task automatic test_first_load();
    bit seen;
    bit extra;
    reply(mk_word(8'h00), 1'b0);
    total++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_load: got %h/%b want 00/1", data_out, data_out_valid);
    end
    wait_need(5, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL prefetch_req: need_next=0 want 1");
    end
    reply(mk_word(8'h40), 1'b0);
    total++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL prefetch_hold: got %h/%b want 00/1", data_out, data_out_valid);
    end
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (need_next) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin
      bad++;
      $display("FAIL full_no_req: need_next seen=%b want 0", extra);
    end
  endtask

  task automatic test_stepping();
    logic [7:0] exp;
    for (int k = 1; k < 32; k++) begin
      exp = 8'(k);
      H = 1'b1; tick();
      total++;
      if (data_out !== exp) begin
        bad++;
        $display("FAIL step%0d: data_out=%h want %h", k, data_out, exp);
      end
      H = 1'b0; tick();
      total++;
      if (data_out !== exp) begin
        bad++;
        $display("FAIL stable%0d: data_out=%h want %h", k, data_out, exp);
      end
    end
    // Swap edge; hold the generator busy so nxt stays empty for the next test.
    H = 1'b1; generator_busy = 1'b1; tick();
    total++;
    if (data_out !== 8'h40 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL swap: got %h/%b want 40/1", data_out, data_out_valid);
    end
    H = 1'b0; tick();
  endtask

  task automatic test_starvation();
    bit saw_req;
    bit seen;
    logic [7:0] exp;
    saw_req = 1'b0;
    for (int k = 1; k < 32; k++) begin
      exp = 8'h40 + 8'(k);
      H = 1'b1; tick();
      if (need_next) saw_req = 1'b1;
      total++;
      if (data_out !== exp || data_out_valid !== 1'b1) begin
        bad++;
        $display("FAIL starve_step%0d: got %h/%b want %h/1", k, data_out, data_out_valid, exp);
      end
      H = 1'b0; tick();
      if (need_next) saw_req = 1'b1;
    end
    H = 1'b1; tick();
    total++;
    if (data_out_valid !== 1'b0 || data_out !== 8'h5f) begin
      bad++;
      $display("FAIL starve_drop: got %h/%b want 5f/0", data_out, data_out_valid);
    end
    H = 1'b0; tick();
    H = 1'b1; tick();
    H = 1'b0; tick();
    if (need_next) saw_req = 1'b1;
    total++;
    if (data_out_valid !== 1'b0 || data_out !== 8'h5f) begin
      bad++;
      $display("FAIL starve_idle_edge: got %h/%b want 5f/0", data_out, data_out_valid);
    end
    total++;
    if (saw_req !== 1'b0) begin
      bad++;
      $display("FAIL busy_blocks_req: need_next seen=%b want 0", saw_req);
    end
    generator_busy = 1'b0;
    wait_need(5, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL starve_req: need_next=0 want 1");
    end
    reply(mk_word(8'h80), 1'b0);
    total++;
    if (data_out !== 8'h80 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL starve_reload: got %h/%b want 80/1", data_out, data_out_valid);
    end
    wait_need(5, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL starve_prefetch: need_next=0 want 1");
    end
    reply(mk_word(8'hc0), 1'b0);
    for (int k = 1; k < 3; k++) begin
      exp = 8'h80 + 8'(k);
      H = 1'b1; tick();
      total++;
      if (data_out !== exp) begin
        bad++;
        $display("FAIL restep%0d: data_out=%h want %h", k, data_out, exp);
      end
      H = 1'b0; tick();
    end
  endtask

  task automatic test_flush();
    bit saw_req;
    bit saw_vld;
    bit seen;
    V = 1'b1; tick();
    total++;
    if (data_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid: data_out_valid=%b want 0", data_out_valid);
    end
    saw_req = 1'b0;
    saw_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin data_in = mk_word(8'he0); data_in_valid = 1'b1; end
      if (i == 3) data_in_valid = 1'b0;
      if (i == 4) H = 1'b1;
      if (i == 5) H = 1'b0;
      tick();
      if (need_next) saw_req = 1'b1;
      if (data_out_valid) saw_vld = 1'b1;
    end
    total++;
    if (saw_req !== 1'b0) begin
      bad++;
      $display("FAIL vblank_no_req: need_next seen=%b want 0", saw_req);
    end
    total++;
    if (saw_vld !== 1'b0) begin
      bad++;
      $display("FAIL vblank_ignore: data_out_valid seen=%b want 0", saw_vld);
    end
    V = 1'b0;
    wait_need(5, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL post_flush_req: need_next=0 want 1");
    end
    reply(mk_word(8'h00), 1'b1);
    total++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_flush_load: got %h/%b want 00/1", data_out, data_out_valid);
    end
  endtask

  task automatic test_same_cycle();
    bit seen;
    for (int k = 1; k < 32; k++) begin
      H = 1'b1; tick();
      H = 1'b0; tick();
    end
    total++;
    if (data_out !== 8'h1f || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL last_chunk: got %h/%b want 1f/1", data_out, data_out_valid);
    end
    generator_busy = 1'b0;
    wait_need(5, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL same_req: need_next=0 want 1");
    end
    generator_busy = 1'b1;
    H = 1'b1;
    data_in = mk_word(8'h40);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    total++;
    if (data_out !== 8'h40 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle: got %h/%b want 40/1", data_out, data_out_valid);
    end
    H = 1'b0; tick();
    total++;
    if (data_out !== 8'h40 || data_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_hold: got %h/%b want 40/1", data_out, data_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    generator_busy = 1'b0;
    reset_n = 1'b0;
    #2;
    total++;
    if ({data_out, data_out_valid, need_next} !== 10'b0) begin
      bad++;
      $display("FAIL mid_reset: got %h/%b/%b want 00/0/0", data_out, data_out_valid, need_next);
    end
    tick(); tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (need_next) pulses++;
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL mid_reset_req: pulses=%0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_stepping();
    test_starvation();
    test_flush();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
